apu_sq_env_len: RTL and testbench
=================================

# apu_sq_env_len

Envelope, length-counter and frame-sequencer stage for a square-wave APU channel. Sits directly upstream of the APU mixer/DAC: it turns the NRx1/NRx2/NRx4 register values and write pulses into the 4-bit live `volume` and `ch_on` that the mixer multiplies against the duty-cycle bit. It also exports the 512 Hz frame-sequencer ticks, including the sweep tick that channel 1 needs.

## Interface
Parameters:
- `DIV`, default 8192: `ce` pulses per frame-sequencer step (4.194304 MHz / 512 Hz).

Ports (clock and reset first):
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high (already decided)
- `ce`  in  1  GB-rate clock enable, one `clk` cycle wide
- `apu_on`  in  1  NR52[7]
- `len_load`  in  1  one-cycle pulse on an NRx1 write
- `len_data`  in  6  NRx1[5:0]
- `trigger`  in  1  one-cycle pulse on an NRx4 write with bit 7 = 1
- `len_en`  in  1  NRx4[6]
- `env_init`  in  4  NRx2[7:4]
- `env_dir`  in  1  NRx2[3]; 1 = up
- `env_period`  in  3  NRx2[2:0]
- `volume`  out  4  live volume; forced to 0 when `ch_on` = 0
- `ch_on`  out  1  channel active (NR52 status bit)
- `len_tick`  out  1  length clock pulse
- `sweep_tick`  out  1  sweep clock pulse
- `env_tick`  out  1  envelope clock pulse
- `fs_step`  out  3  current frame-sequencer step

## Operation
- **Divider:** counts `ce` pulses from 0 to DIV-1. On the pulse at DIV-1 it wraps to 0 and `fs_step` increments modulo 8.
- **Ticks:** on entering step s, emit one registered pulse, exactly 1 `clk` cycle wide:
  - `len_tick` when s is even
  - `sweep_tick` when s = 2 or s = 6
  - `env_tick` when s = 7
- **Length counter:** `len_cnt` is 7 bits, range 0..64.
  - On `len_load`: `len_cnt` ← 64 − `len_data`.
  - On `len_tick` with `len_en` = 1 and `len_cnt` ≠ 0: decrement. Reaching 0 clears `ch_on`.
- **DAC enable:** `dac_on` = (`env_init` ≠ 0) | `env_dir`. While `dac_on` = 0, `ch_on` is cleared combinationally in the same cycle as the register change.
- **Trigger:**
  - `ch_on` ← `dac_on`.
  - If `len_cnt` = 0, `len_cnt` ← 64.
  - `vol` ← `env_init`.
  - `env_timer` ← `env_period`.
- **Envelope:** on `env_tick`:
  - If `env_period` = 0: no change.
  - Else if `env_timer` ≤ 1: reload `env_timer` from `env_period`, then step `vol` by +1 when `env_dir` = 1 and `vol` < 15, or by −1 when `env_dir` = 0 and `vol` > 0. Saturating, never wraps.
  - Else: decrement `env_timer`.
- **Simultaneous events:**
  - `trigger` together with `len_tick` or `env_tick`: trigger wins; no decrement or step that cycle.
  - `len_load` together with `trigger`: the load applies first, then the trigger tests the loaded value.
- **`apu_on` = 0:**
  - Divider and `fs_step` held at 0.
  - All ticks, `ch_on`, `vol` and `env_timer` held at 0.
  - `len_cnt` retained.
  - `trigger` ignored.
- **Reset:** every register and output is 0 (`fs_step` 0, all ticks 0, `volume` 0, `ch_on` 0, `len_cnt` 0).

## Timing
- Tick latency: the tick pulse and the new `fs_step` appear in the `clk` cycle after the wrapping `ce` pulse.
- `ch_on` and `volume` update in the `clk` cycle after the causing `trigger`, `len_load` or tick cycle.
- The block consumes its own ticks in the same cycle they are high, so the `ch_on` and `volume` effects appear one cycle after the tick.
- `ce` may be high every cycle; no handshake is needed. Inputs are sampled every `clk`.
- `rst` or `apu_on` falling mid-step: the divider restarts from 0 and the first step after re-enable is entered after DIV `ce` pulses, as step 1.

## Structure
- `apu_pkg` holds:
  - `FS_DIV_DEFAULT` = 8192
  - `typedef logic [2:0] fs_step_t`
  - step-mask constants `LEN_STEPS` = 8'b0101_0101, `SWEEP_STEPS` = 8'b0100_0100, `ENV_STEPS` = 8'b1000_0000
- Sub-module `apu_frame_seq` (divider, step counter, tick generation) is instantiated once. Channel 1's sweep unit reuses it later.

## Test plan
(All scenarios use DIV = 4, `ce` = 1.)
1. **Reset and tick sequence:** release `rst`, `apu_on` = 1 → `len_tick` pulses at steps 2, 4, 6, 0; `sweep_tick` at steps 2, 6; `env_tick` at step 7; each pulse is exactly 1 cycle wide.
2. **Length expiry:** `len_data` = 62, `len_load`, then `trigger` with `len_en` = 1 and `env_init` = 15 → `ch_on` = 1 → `ch_on` drops to 0 one cycle after the 2nd `len_tick`.
3. **Envelope down:** `env_init` = 3, `env_dir` = 0, `env_period` = 1, `trigger` → `volume` 3, then 2, 1, 0 on successive `env_tick`s, then stays 0. With `env_dir` = 1 and `env_init` = 14 → `volume` 15 and holds.
4. **DAC off:** channel active, then `env_init` = 0 with `env_dir` = 0 → `ch_on` = 0 and `volume` = 0 immediately. A subsequent `trigger` leaves `ch_on` = 0.
5. **Simultaneous events:** `trigger` on a `len_tick` cycle with `len_cnt` = 0 → `len_cnt` = 64, not 63. `len_load` (`len_data` = 10) with `trigger` in the same cycle → `len_cnt` = 54.
6. **APU power-off:** `apu_on` 1→0 mid-step → `fs_step` 0, `ch_on` 0, `len_cnt` unchanged. On re-enable, the first tick after 4 `ce` pulses is at step 1 (no `len_tick`).

Source files
------------

// File: rtl/apu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apu_pkg: shared frame-sequencer constants and types for the APU channels. rev 1.0
// ----------------------------------------------------------------------------
package apu_pkg;

  localparam int FS_DIV_DEFAULT = 8192;

  typedef logic [2:0] fs_step_t;

  // Bit s set means the corresponding tick fires on entry to step s.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

endpackage
`default_nettype wire

// File: rtl/apu_frame_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apu_frame_seq: ce divider, 8-step frame sequencer and registered tick pulses. rev 1.0
// ----------------------------------------------------------------------------
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int DIV = FS_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       apu_on,
  output logic [2:0] fs_step,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  fs_step_t      next_step;

  assign next_step = fs_step + 3'd1;

  // Power-off restarts the divider so the first step after re-enable is a full period away.
  always_ff @(posedge clk) begin
    if (rst || !apu_on) begin
      div_cnt    <= '0;
      fs_step    <= '0;
      len_tick   <= 1'b0;
      sweep_tick <= 1'b0;
      env_tick   <= 1'b0;
    end else begin
      len_tick   <= 1'b0;
      sweep_tick <= 1'b0;
      env_tick   <= 1'b0;
      if (ce) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt    <= '0;
          fs_step    <= next_step;
          len_tick   <= LEN_STEPS[next_step];
          sweep_tick <= SWEEP_STEPS[next_step];
          env_tick   <= ENV_STEPS[next_step];
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apu_sq_env_len.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apu_sq_env_len: square-channel envelope, length counter and frame-sequencer stage. rev 1.0
// ----------------------------------------------------------------------------
module apu_sq_env_len
  import apu_pkg::*;
#(
  parameter int DIV = FS_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       apu_on,
  input  logic       len_load,
  input  logic [5:0] len_data,
  input  logic       trigger,
  input  logic       len_en,
  input  logic [3:0] env_init,
  input  logic       env_dir,
  input  logic [2:0] env_period,
  output logic [3:0] volume,
  output logic       ch_on,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic [2:0] fs_step
);

  logic [6:0] len_cnt;
  logic [6:0] len_loaded;
  logic [3:0] vol;
  logic [2:0] env_timer;
  logic       ch_on_r;
  logic       dac_on;
  logic       trig;
  logic       len_dec;

  apu_frame_seq #(
    .DIV(DIV)
  ) u_frame_seq (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .apu_on    (apu_on),
    .fs_step   (fs_step),
    .len_tick  (len_tick),
    .sweep_tick(sweep_tick),
    .env_tick  (env_tick)
  );

  assign dac_on = (env_init != 4'd0) | env_dir;
  assign trig   = trigger & apu_on;

  // A same-cycle load is visible to the trigger's zero test.
  assign len_loaded = len_load ? (7'd64 - {1'b0, len_data}) : len_cnt;
  assign len_dec    = len_tick & len_en & (len_cnt != 7'd0) & ~len_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt <= '0;
    end else if (trig) begin
      len_cnt <= (len_loaded == 7'd0) ? 7'd64 : len_loaded;
    end else if (len_load) begin
      len_cnt <= len_loaded;
    end else if (len_dec) begin
      len_cnt <= len_cnt - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !apu_on || !dac_on) begin
      ch_on_r <= 1'b0;
    end else if (trig) begin
      ch_on_r <= 1'b1;
    end else if (len_dec && (len_cnt == 7'd1)) begin
      ch_on_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !apu_on) begin
      vol       <= '0;
      env_timer <= '0;
    end else if (trig) begin
      vol       <= env_init;
      env_timer <= env_period;
    end else if (env_tick && (env_period != 3'd0)) begin
      if (env_timer <= 3'd1) begin
        env_timer <= env_period;
        if (env_dir && (vol != 4'd15)) begin
          vol <= vol + 4'd1;
        end else if (!env_dir && (vol != 4'd0)) begin
          vol <= vol - 4'd1;
        end
      end else begin
        env_timer <= env_timer - 3'd1;
      end
    end
  end

  // The DAC gate is combinational so a register write silences the channel immediately.
  assign ch_on  = ch_on_r & dac_on;
  assign volume = ch_on ? vol : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_apu_sq_env_len.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_apu_sq_env_len: scoreboard bench for the envelope/length/frame-sequencer stage. rev 1.0
// ----------------------------------------------------------------------------
module tb_apu_sq_env_len;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, ce, apu_on, len_load, trigger, len_en, env_dir;
  logic [5:0] len_data;
  logic [3:0] env_init;
  logic [2:0] env_period;
  logic [3:0] volume;
  logic       ch_on, len_tick, sweep_tick, env_tick;
  logic [2:0] fs_step;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] got;
  bit          found;

  always #5 clk = ~clk;

  apu_sq_env_len #(
    .DIV(DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .apu_on    (apu_on),
    .len_load  (len_load),
    .len_data  (len_data),
    .trigger   (trigger),
    .len_en    (len_en),
    .env_init  (env_init),
    .env_dir   (env_dir),
    .env_period(env_period),
    .volume    (volume),
    .ch_on     (ch_on),
    .len_tick  (len_tick),
    .sweep_tick(sweep_tick),
    .env_tick  (env_tick),
    .fs_step   (fs_step)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sel 0 = len_tick, 1 = env_tick; returns with the tick high in the current cycle.
  task automatic wait_for(input int sel, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if ((sel == 0 && len_tick) || (sel == 1 && env_tick)) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  // Expected {step, len, sweep, env} k clock edges after the sequencer starts from step 0.
  function automatic logic [15:0] fs_exp(input int k);
    int  s;
    bit  t;
    s = (k / DIV) % 8;
    t = (k > 0) && (k % DIV == 0);
    return {10'd0, 3'(s), t && (s % 2 == 0), t && (s == 2 || s == 6), t && (s == 7)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; apu_on = 1'b1; ce = 1'b1; len_load = 1'b0; trigger = 1'b0;
    len_en = 1'b0; env_dir = 1'b0; len_data = '0; env_init = '0; env_period = '0;
    sb.push_back('{"reset_outputs", 16'd0});
    sb.push_back('{"reset_len_cnt", 16'd0});
    repeat (3) cyc();
    got = {5'd0, fs_step, len_tick, sweep_tick, env_tick, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    got = {9'd0, dut.len_cnt};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_tick_sequence();
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      sb.push_back('{$sformatf("tick_seq_k%0d", k), fs_exp(k)});
      cyc();
      got = {10'd0, fs_step, len_tick, sweep_tick, env_tick};
      e = sb.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_len_expiry();
    env_init = 4'd15; env_dir = 1'b0; env_period = 3'd0; len_en = 1'b1;
    wait_for(0, found);
    checks++;
    if (!found) begin errors++; $display("FAIL len_wait0: got no len_tick expected len_tick"); end
    cyc();
    len_data = 6'd62; len_load = 1'b1;
    cyc();
    len_load = 1'b0; trigger = 1'b1;
    sb.push_back('{"len_trig_on", 16'h001F});
    cyc();
    trigger = 1'b0;
    got = {11'd0, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"len_after_1st", 16'd1});
    sb.push_back('{"len_during_2nd", 16'd1});
    sb.push_back('{"len_after_2nd", 16'd0});
    wait_for(0, found);
    cyc();
    got = {15'd0, ch_on};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    wait_for(0, found);
    got = {15'd0, ch_on};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cyc();
    got = {11'd0, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_simultaneous();
    wait_for(0, found);
    checks++;
    if (!found) begin errors++; $display("FAIL sim_wait: got no len_tick expected len_tick"); end
    trigger = 1'b1;
    sb.push_back('{"trig_on_len_tick", 16'd64});
    cyc();
    trigger = 1'b0;
    got = {9'd0, dut.len_cnt};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    len_data = 6'd10; len_load = 1'b1; trigger = 1'b1;
    sb.push_back('{"load_with_trig", 16'd54});
    cyc();
    len_load = 1'b0; trigger = 1'b0; len_en = 1'b0;
    got = {9'd0, dut.len_cnt};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_envelope();
    logic [3:0] steps[6] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd15, 4'd15};
    env_init = 4'd3; env_dir = 1'b0; env_period = 3'd1;
    wait_for(1, found);
    cyc();
    trigger = 1'b1;
    sb.push_back('{"env_trig_vol", 16'd3});
    cyc();
    trigger = 1'b0;
    got = {12'd0, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        env_dir = 1'b1; env_init = 4'd14; trigger = 1'b1;
        sb.push_back('{"env_up_trig", 16'd14});
        cyc();
        trigger = 1'b0;
        got = {12'd0, volume};
        e = sb.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
      end
      sb.push_back('{$sformatf("env_step%0d", i), {12'd0, steps[i]}});
      wait_for(1, found);
      cyc();
      got = {12'd0, volume};
      e = sb.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_dac_off();
    sb.push_back('{"dac_pre_on", 16'd1});
    got = {15'd0, ch_on};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    env_init = 4'd0; env_dir = 1'b0;
    sb.push_back('{"dac_off_immediate", 16'd0});
    #1;
    got = {11'd0, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cyc();
    trigger = 1'b1;
    sb.push_back('{"dac_off_trigger", 16'd0});
    cyc();
    trigger = 1'b0;
    got = {11'd0, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_power_off();
    env_init = 4'd15; env_dir = 1'b0; env_period = 3'd0; trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    wait_for(0, found);
    cyc();
    cyc();
    apu_on = 1'b0;
    sb.push_back('{"pwr_off_state", 16'd0});
    sb.push_back('{"pwr_off_len_cnt", 16'd54});
    cyc();
    got = {5'd0, fs_step, len_tick, sweep_tick, env_tick, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    got = {9'd0, dut.len_cnt};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    trigger = 1'b1;
    sb.push_back('{"pwr_off_trigger", 16'd0});
    cyc();
    trigger = 1'b0;
    cyc();
    got = {5'd0, fs_step, len_tick, sweep_tick, env_tick, ch_on, volume};
    e = sb.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    apu_on = 1'b1;
    for (int k = 1; k <= 2 * DIV; k++) begin
      sb.push_back('{$sformatf("reenable_k%0d", k), fs_exp(k)});
      cyc();
      got = {10'd0, fs_step, len_tick, sweep_tick, env_tick};
      e = sb.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_tick_sequence();
    test_len_expiry();
    test_simultaneous();
    test_envelope();
    test_dac_off();
    test_power_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
